// File: rtl/dm_responder.sv
// Data-memory responder: word RAM behind a request/response handshake
// with a programmable number of wait states before each access commits.
module dm_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  LAT   = 4'(LATENCY);
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        commit;
   logic        c_we;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic [31:0] off;
   logic [AW-1:0] idx;
   logic        acc_err;
   logic        mem_we;
   logic [31:0] mem_rd;

   logic [31:0] mem_q [DEPTH_WORDS];

   // Offset is unsigned, so addresses below BASE_ADDR wrap out of range.
   assign off     = c_addr - BASE_ADDR;
   assign idx     = off[AW+1:2];
   assign acc_err = (|c_addr[1:0]) | ({1'b0, off} >= LIMIT);
   assign mem_rd  = mem_q[idx];
   assign mem_we  = commit & c_we & ~acc_err & ~rst;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      commit  = 1'b0;
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (LAT == 4'd0) begin
                  commit  = 1'b1;
                  c_we    = req_we;
                  c_addr  = req_addr;
                  c_wdata = req_wdata;
                  state_d = RESP;
               end else begin
                  cnt_d   = LAT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (commit) begin
         err_d   = acc_err;
         rdata_d = (!acc_err && !c_we) ? mem_rd : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx] <= c_wdata;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: default, zero-latency and
// offset-base instances driven one at a time.
module tb_dm_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   = 1'b1;
   logic [2:0]  vld   = 3'b000;
   logic        we    = 1'b0;
   logic [31:0] addr  = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        rrdy  = 1'b1;

   logic        rq0, rq1, rq2;
   logic        rv0, rv1, rv2;
   logic        er0, er1, er2;
   logic [31:0] rd0, rd1, rd2;

   logic [1:0]  sel = 2'd0;
   logic        rq, rv, er;
   logic [31:0] rd;

   int n_tests = 0;
   int n_fail  = 0;

   dm_responder u_a (
      .clk(clk), .rst(rst),
      .req_valid(vld[0]), .req_ready(rq0),
      .req_we(we), .req_addr(addr), .req_wdata(wdata),
      .resp_valid(rv0), .resp_ready(rrdy),
      .resp_rdata(rd0), .resp_err(er0)
   );

   dm_responder #(.LATENCY(0)) u_b (
      .clk(clk), .rst(rst),
      .req_valid(vld[1]), .req_ready(rq1),
      .req_we(we), .req_addr(addr), .req_wdata(wdata),
      .resp_valid(rv1), .resp_ready(rrdy),
      .resp_rdata(rd1), .resp_err(er1)
   );

   dm_responder #(.BASE_ADDR(32'h0000_1000)) u_c (
      .clk(clk), .rst(rst),
      .req_valid(vld[2]), .req_ready(rq2),
      .req_we(we), .req_addr(addr), .req_wdata(wdata),
      .resp_valid(rv2), .resp_ready(rrdy),
      .resp_rdata(rd2), .resp_err(er2)
   );

   always_comb begin
      rq = rq0; rv = rv0; er = er0; rd = rd0;
      case (sel)
         2'd1: begin rq = rq1; rv = rv1; er = er1; rd = rd1; end
         2'd2: begin rq = rq2; rv = rv2; er = er2; rd = rd2; end
         default: ;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request with resp_ready high; reports cycles to response.
   task automatic issue(input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat,
                        output int low, output logic [31:0] data,
                        output logic e);
      we = w; addr = a; wdata = d;
      vld = 3'b001 << sel;
      tick();
      vld = 3'b000;
      lat = -1; low = 0; data = 'x; e = 1'bx;
      for (int i = 1; i <= 40; i++) begin
         if (!rq) low++;
         if (rv) begin
            lat = i; data = rd; e = er;
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_tests++;
      if ({rq0, rv0, er0} !== 3'b100) begin
         n_fail++;
         $display("FAIL rst_flags got %b want 100", {rq0, rv0, er0});
      end
      n_tests++;
      if (rd0 !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_rdata got %h want 0", rd0);
      end
      n_tests++;
      if ({rq1, rv1, rq2, rv2} !== 4'b1010) begin
         n_fail++;
         $display("FAIL rst_others got %b want 1010", {rq1, rv1, rq2, rv2});
      end
   endtask

   task automatic test_store_load();
      int lat, low; logic [31:0] d; logic e;
      sel = 2'd0; rrdy = 1'b1; tick();
      issue(1'b1, 32'h10, 32'hDEAD_BEEF, lat, low, d, e);
      n_tests++;
      if (lat !== 3 || low !== 3) begin
         n_fail++;
         $display("FAIL st_timing got lat=%0d low=%0d want 3 3", lat, low);
      end
      n_tests++;
      if (d !== 32'h0 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL st_resp got %h/%b want 0/0", d, e);
      end
      issue(1'b0, 32'h10, 32'h0, lat, low, d, e);
      n_tests++;
      if (lat !== 3 || low !== 3) begin
         n_fail++;
         $display("FAIL ld_timing got lat=%0d low=%0d want 3 3", lat, low);
      end
      n_tests++;
      if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
         n_fail++;
         $display("FAIL ld_resp got %h/%b want deadbeef/0", d, e);
      end
   endtask

   task automatic test_errors();
      int lat, low; logic [31:0] d; logic e;
      sel = 2'd0; rrdy = 1'b1;
      issue(1'b1, 32'h0, 32'hA5A5_0001, lat, low, d, e);
      issue(1'b0, 32'h12, 32'h0, lat, low, d, e);
      n_tests++;
      if (d !== 32'h0 || e !== 1'b1) begin
         n_fail++;
         $display("FAIL err_misld got %h/%b want 0/1", d, e);
      end
      issue(1'b1, 32'h1000, 32'hFFFF_FFFF, lat, low, d, e);
      n_tests++;
      if (d !== 32'h0 || e !== 1'b1) begin
         n_fail++;
         $display("FAIL err_oorst got %h/%b want 0/1", d, e);
      end
      issue(1'b1, 32'h2, 32'h5555_5555, lat, low, d, e);
      n_tests++;
      if (d !== 32'h0 || e !== 1'b1) begin
         n_fail++;
         $display("FAIL err_misst got %h/%b want 0/1", d, e);
      end
      issue(1'b0, 32'h0, 32'h0, lat, low, d, e);
      n_tests++;
      if (d !== 32'hA5A5_0001 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL err_word0 got %h/%b want a5a50001/0", d, e);
      end
   endtask

   task automatic test_backpressure();
      sel = 2'd0; rrdy = 1'b0;
      we = 1'b0; addr = 32'h10; vld = 3'b001;
      tick();
      vld = 3'b000;
      for (int i = 0; i < 20 && !rv; i++) tick();
      n_tests++;
      if (rv !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_rise got %b want 1", rv);
      end
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if ({rv, er, rq} !== 3'b100 || rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bp_hold%0d got v/e/rq=%b rd=%h want 100 deadbeef",
                     k, {rv, er, rq}, rd);
         end
         if (k < 4) begin
            addr = 32'h100 + 32'(k * 4); we = 1'b1; vld = 3'b001;
            tick();
         end
      end
      vld = 3'b000; we = 1'b0; rrdy = 1'b1;
      tick();
      n_tests++;
      if ({rv, rq} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_consume got v/rq=%b want 01", {rv, rq});
      end
   endtask

   task automatic test_reset_mid();
      int lat, low; logic [31:0] d; logic e;
      sel = 2'd0; rrdy = 1'b1;
      issue(1'b1, 32'h20, 32'hCAFE_0020, lat, low, d, e);
      we = 1'b1; addr = 32'h20; wdata = 32'h1234; vld = 3'b001;
      tick();
      vld = 3'b000;
      tick();
      rst = 1'b1;
      tick();
      n_tests++;
      if ({rv0, rq0} !== 2'b01) begin
         n_fail++;
         $display("FAIL rw_flags got v/rq=%b want 01", {rv0, rq0});
      end
      rst = 1'b0;
      issue(1'b0, 32'h20, 32'h0, lat, low, d, e);
      n_tests++;
      if (d !== 32'hCAFE_0020 || e !== 1'b0 || lat !== 3) begin
         n_fail++;
         $display("FAIL rw_load got %h/%b lat=%0d want cafe0020/0 3", d, e, lat);
      end
      rrdy = 1'b0;
      we = 1'b0; addr = 32'h20; vld = 3'b001;
      tick();
      vld = 3'b000;
      for (int i = 0; i < 20 && !rv; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (rv0 !== 1'b0 || rd0 !== 32'h0) begin
         n_fail++;
         $display("FAIL rr_drop got v=%b rd=%h want 0 0", rv0, rd0);
      end
      rrdy = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      sel = 2'd1; rrdy = 1'b1; tick();
      we = 1'b1; addr = 32'h4; wdata = 32'h0BAD_F00D; vld = 3'b010;
      tick();
      n_tests++;
      if ({rv, rq, er} !== 3'b100 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL b2b_st got v/rq/e=%b rd=%h want 100 0", {rv, rq, er}, rd);
      end
      we = 1'b0; wdata = 32'h0;
      tick();
      n_tests++;
      if ({rv, rq} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_gap got v/rq=%b want 01", {rv, rq});
      end
      tick();
      vld = 3'b000;
      n_tests++;
      if ({rv, er} !== 2'b10 || rd !== 32'h0BAD_F00D) begin
         n_fail++;
         $display("FAIL b2b_ld got v/e=%b rd=%h want 10 0badf00d", {rv, er}, rd);
      end
      tick();
      n_tests++;
      if ({rv, rq} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_end got v/rq=%b want 01", {rv, rq});
      end
   endtask

   task automatic test_base();
      int lat, low; logic [31:0] d; logic e;
      sel = 2'd2; rrdy = 1'b1; tick();
      issue(1'b0, 32'h0FFC, 32'h0, lat, low, d, e);
      n_tests++;
      if (d !== 32'h0 || e !== 1'b1) begin
         n_fail++;
         $display("FAIL base_below got %h/%b want 0/1", d, e);
      end
      issue(1'b1, 32'h1000, 32'h600D_0000, lat, low, d, e);
      n_tests++;
      if (d !== 32'h0 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL base_st got %h/%b want 0/0", d, e);
      end
      issue(1'b0, 32'h1000, 32'h0, lat, low, d, e);
      n_tests++;
      if (d !== 32'h600D_0000 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL base_ld got %h/%b want 600d0000/0", d, e);
      end
      issue(1'b0, 32'h2000, 32'h0, lat, low, d, e);
      n_tests++;
      if (d !== 32'h0 || e !== 1'b1) begin
         n_fail++;
         $display("FAIL base_top got %h/%b want 0/1", d, e);
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_base();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
